uart_loader_ctrl: RTL and testbench
===================================

// Module: uart_loader_ctrl
// PURPOSE
//  Command sequencer between the UART byte receiver/transmitter and the CPU instruction-memory debug port.
//  Parses host byte stream: write = 5 bytes {1,addr[6:0]}, d[7:0], d[15:8], d[23:16], d[31:24];
//  read = 1 byte {0,addr[6:0]}, answered with 4 bytes of mem word, LSB first.
//  Sits inside cpu_top; drives memory only while CPU is held in reset by the host.
// PARAMETERS
//  ADDR_W          7       memory word-address width (= command-byte addr field)
//  DATA_W          32      memory word width; fixed 4 bytes per word
//  TIMEOUT_CYCLES  262144  max clk cycles between bytes of one write frame (timeout build only)
// PORTS
//  clk        in   1       system clock, all logic on posedge
//  reset      in   1       synchronous, active-high
//  rx_data    in   8       received UART byte
//  rx_valid   in   1       1-cycle strobe, rx_data valid
//  tx_data    out  8       byte to transmit
//  tx_valid   out  1       tx_data valid; held until accepted
//  tx_ready   in   1       transmitter can accept; transfer when tx_valid & tx_ready
//  mem_addr   out  ADDR_W  memory word address
//  mem_wdata  out  DATA_W  write data
//  mem_we     out  1       1-cycle write strobe
//  mem_rdata  in   DATA_W  read data, 1-cycle synchronous latency after mem_addr
//  busy       out  1       high in any state other than IDLE
//  overrun    out  1       sticky: byte arrived while not accepting
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, byte counter 0; mid-frame reset discards frame, no write issued.
//  FSM states: IDLE, WDATA, WRITE, RADDR, RWAIT, RSEND.
//  IDLE: rx_valid -> latch addr=rx_data[6:0]; bit7=1 -> WDATA (cnt=0); bit7=0 -> RADDR.
//  WDATA: each rx_valid stores byte into wdata[8*cnt+:8], cnt++; after cnt==3 byte -> WRITE.
//  WRITE: mem_we=1 exactly one cycle, mem_addr/mem_wdata stable that cycle -> IDLE.
//    Latency: mem_we high the cycle after the 4th data byte strobe.
//  RADDR: mem_addr driven (1 cycle) -> RWAIT; RWAIT: capture mem_rdata into shift reg -> RSEND, cnt=0.
//  RSEND: tx_valid=1, tx_data=word[8*cnt+:8]; on tx_valid&tx_ready cnt++; after 4th accept -> IDLE,
//    tx_valid drops the cycle after last accept; tx_data never changes while tx_valid & !tx_ready.
//  rx_valid in WRITE/RADDR/RWAIT/RSEND: byte dropped, overrun<=1 (sticky until reset).
//  rx_valid and tx_ready same cycle in RSEND: tx handshake proceeds, byte dropped, overrun set.
//  Address 7'h7F valid, no wrap beyond ADDR_W; mem_addr holds last value when IDLE.
//  mem_we never asserted outside WRITE; cmd byte 8'h80 writes address 0.
// CONFIGURATION
//  UART_LOADER_TIMEOUT_EN defined: counter clears on each accepted byte in WDATA; reaching
//    TIMEOUT_CYCLES in WDATA -> abandon frame, IDLE, no write, cnt=0.
//  Not defined: WDATA waits indefinitely; counter logic absent.
// TESTING
//  Write {8'h85,8'h05,8'h00,8'h05,8'h20} -> one mem_we pulse, mem_addr=5, mem_wdata=32'h20050005.
//  Read 8'h05 after above, mem model returns 32'h20050005 -> tx bytes 05,00,05,20 in order, busy low after.
//  Read with tx_ready low 10 cycles per byte -> tx_data stable while stalled, exactly 4 transfers.
//  Extra byte 8'hAA during RSEND -> overrun=1, no state change, no mem_we.
//  reset pulsed after 2 data bytes of write to addr 3 -> no mem_we, next read of 3 returns old word.
//  UART_LOADER_TIMEOUT_EN, TIMEOUT_CYCLES=100: 3 data bytes then 100 idle cycles -> IDLE, no mem_we; next byte parsed as command.

Source files
------------

// File: rtl/uart_loader_ctrl.sv
// UART command sequencer for the instruction-memory debug port: 5-byte write frames, 1-byte read requests.
// Define UART_LOADER_TIMEOUT_EN to abandon write frames whose data bytes stall for TIMEOUT_CYCLES.
module uart_loader_ctrl #(
  parameter int ADDR_W         = 7,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 262144
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic [2:0] {IDLE, WDATA, WRITE, RADDR, RWAIT, RSEND} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] word_reg;
  logic [1:0]        cnt_reg;
  logic              overrun_reg;
  logic              timeout_hit;
  logic              tx_fire;

  assign tx_fire = (state_reg == RSEND) && tx_ready;

`ifdef UART_LOADER_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] timer_reg;

  // Counts idle cycles between data bytes; any accepted byte restarts the window.
  always_ff @(posedge clk) begin
    if (reset || state_reg != WDATA || rx_valid)
      timer_reg <= '0;
    else
      timer_reg <= timer_reg + 1'b1;
  end

  assign timeout_hit = (state_reg == WDATA) && !rx_valid &&
                       (timer_reg == TMR_W'(TIMEOUT_CYCLES));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (rx_valid) state_next = rx_data[7] ? WDATA : RADDR;
      WDATA: begin
        if (timeout_hit)
          state_next = IDLE;
        else if (rx_valid && cnt_reg == 2'd3)
          state_next = WRITE;
      end
      WRITE: state_next = IDLE;
      RADDR: state_next = RWAIT;
      RWAIT: state_next = RSEND;
      RSEND: if (tx_fire && cnt_reg == 2'd3) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_reg    <= '0;
      wdata_reg   <= '0;
      word_reg    <= '0;
      cnt_reg     <= '0;
      overrun_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (rx_valid) begin
            addr_reg <= rx_data[ADDR_W-1:0];
            cnt_reg  <= '0;
          end
        end
        WDATA: begin
          if (timeout_hit) begin
            cnt_reg <= '0;
          end else if (rx_valid) begin
            wdata_reg[8*cnt_reg +: 8] <= rx_data;
            cnt_reg                   <= cnt_reg + 2'd1;
          end
        end
        RWAIT: begin
          word_reg <= mem_rdata;
          cnt_reg  <= '0;
        end
        RSEND: if (tx_fire) cnt_reg <= cnt_reg + 2'd1;
        default: ;
      endcase
      // Only IDLE and WDATA consume bytes; anything else arriving is lost.
      if (rx_valid && state_reg != IDLE && state_reg != WDATA)
        overrun_reg <= 1'b1;
    end
  end

  always_comb begin
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    mem_we   = 1'b0;
    busy     = (state_reg != IDLE);
    case (state_reg)
      WRITE: mem_we = 1'b1;
      RSEND: begin
        tx_valid = 1'b1;
        tx_data  = word_reg[8*cnt_reg +: 8];
      end
      default: ;
    endcase
  end

  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_uart_loader_ctrl.sv
// Directed bench for uart_loader_ctrl: table of write/read frames plus stall, overrun, reset and timeout sequences.
module tb_uart_loader_ctrl;

`ifdef UART_LOADER_TIMEOUT_EN
  localparam int TB_TO = 100;
`else
  localparam int TB_TO = 262144;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        overrun;

  always #5 clk = ~clk;

  uart_loader_ctrl #(.ADDR_W(7), .DATA_W(32), .TIMEOUT_CYCLES(TB_TO)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .busy(busy), .overrun(overrun)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Memory model with one-cycle read latency, plus write and transmit monitors.
  logic [31:0] mem [128];
  int          we_count   = 0;
  logic [7:0]  txq [$];
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data  = 8'h00;

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      we_count      <= we_count + 1;
    end
    mem_rdata <= mem[mem_addr];
    if (tx_valid && tx_ready) txq.push_back(tx_data);
    if (prev_stall) check("tx_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, prev_data});
    prev_stall <= tx_valid && !tx_ready;
    prev_data  <= tx_data;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  function automatic logic [31:0] txq_word();
    logic [31:0] w = '0;
    for (int i = 0; i < txq.size() && i < 4; i++) w[8*i +: 8] = txq[i];
    return w;
  endfunction

  task automatic do_write(input logic [6:0] a, input logic [31:0] d);
    int w0 = we_count;
    send_byte({1'b1, a});
    for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
    check("wr_we_pulse", {31'd0, mem_we}, 32'd1);
    check("wr_addr", {25'd0, mem_addr}, {25'd0, a});
    check("wr_data", mem_wdata, d);
    tick();
    check("wr_we_drop", {31'd0, mem_we}, 32'd0);
    check("wr_busy_after", {31'd0, busy}, 32'd0);
    check("wr_we_count", we_count, w0 + 1);
    $display("write addr=%02h data=%08h", a, d);
  endtask

  task automatic wait_tx(input int want);
    int n = 0;
    while (txq.size() < want && n < 60) begin
      tick();
      n++;
    end
  endtask

  task automatic do_read(input logic [6:0] a, input logic [31:0] exp);
    txq.delete();
    send_byte({1'b0, a});
    wait_tx(4);
    check("rd_xfers", txq.size(), 4);
    check("rd_word", txq_word(), exp);
    check("rd_valid_drop", {31'd0, tx_valid}, 32'd0);
    check("rd_busy_after", {31'd0, busy}, 32'd0);
    check("rd_addr_hold", {25'd0, mem_addr}, {25'd0, a});
    $display("read  addr=%02h word=%08h expect=%08h", a, txq_word(), exp);
  endtask

  typedef struct {
    bit          wr;
    logic [6:0]  addr;
    logic [31:0] data;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int w0;
    int n;
    vecs[0] = '{1'b1, 7'h05, 32'h2005_0005};
    vecs[1] = '{1'b0, 7'h05, 32'h2005_0005};
    vecs[2] = '{1'b1, 7'h00, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 7'h7F, 32'h1234_5678};
    vecs[4] = '{1'b0, 7'h00, 32'hDEAD_BEEF};
    vecs[5] = '{1'b0, 7'h7F, 32'h1234_5678};
    vecs[6] = '{1'b1, 7'h03, 32'hA5A5_0F0F};
    vecs[7] = '{1'b0, 7'h03, 32'hA5A5_0F0F};

    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b1;
    repeat (3) tick();
    check("rst_outputs", {tx_data, 7'd0, tx_valid, mem_addr, mem_we, busy, overrun, 5'd0},
          32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    reset = 1'b0;
    tick();

    foreach (vecs[i]) begin
      if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data);
      else            do_read(vecs[i].addr, vecs[i].data);
    end
    check("no_overrun_yet", {31'd0, overrun}, 32'd0);

    // Read with the transmitter stalled for 10 cycles on every byte.
    tx_ready = 1'b0;
    txq.delete();
    send_byte(8'h05);
    for (int b = 0; b < 4; b++) begin
      n = 0;
      while (!tx_valid && n < 20) begin
        tick();
        n++;
      end
      check("stall_valid", {31'd0, tx_valid}, 32'd1);
      repeat (10) tick();
      check("stall_count", txq.size(), b);
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
    end
    check("stall_word", txq_word(), 32'h2005_0005);
    check("stall_busy", {31'd0, busy}, 32'd0);
    repeat (5) tick();
    check("stall_xfers", txq.size(), 4);
    $display("stall read word=%08h xfers=%0d", txq_word(), txq.size());

    // Extra bytes during RSEND, one alone and one coinciding with a handshake.
    txq.delete();
    send_byte(8'h00);
    n = 0;
    while (!tx_valid && n < 20) begin
      tick();
      n++;
    end
    w0 = we_count;
    send_byte(8'hAA);
    check("ovr_flag", {31'd0, overrun}, 32'd1);
    check("ovr_state", {30'd0, busy, tx_valid}, 32'd3);
    check("ovr_txdata", {24'd0, tx_data}, 32'h0000_00EF);
    rx_data  = 8'hAA;
    rx_valid = 1'b1;
    tx_ready = 1'b1;
    tick();
    rx_valid = 1'b0;
    check("ovr_same_cycle_xfer", txq.size(), 1);
    wait_tx(4);
    check("ovr_word", txq_word(), 32'hDEAD_BEEF);
    check("ovr_no_we", we_count, w0);
    check("ovr_sticky", {31'd0, overrun}, 32'd1);
    $display("overrun read word=%08h overrun=%0b", txq_word(), overrun);

    // Reset in the middle of a write frame to address 3.
    w0 = we_count;
    send_byte(8'h83);
    send_byte(8'h11);
    send_byte(8'h22);
    reset = 1'b1;
    tick();
    tick();
    check("midrst_outputs", {mem_addr, mem_we, busy, overrun, tx_valid}, 32'd0);
    check("midrst_wdata", mem_wdata, 32'd0);
    reset = 1'b0;
    tick();
    check("midrst_no_we", we_count, w0);
    do_read(7'h03, 32'hA5A5_0F0F);
    $display("mid-frame reset: writes=%0d", we_count - w0);

`ifdef UART_LOADER_TIMEOUT_EN
    w0 = we_count;
    send_byte(8'h81);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    repeat (20) tick();
    check("to_still_waiting", {31'd0, busy}, 32'd1);
    repeat (90) tick();
    check("to_idle", {31'd0, busy}, 32'd0);
    check("to_no_we", we_count, w0);
    do_read(7'h05, 32'h2005_0005);
    $display("timeout: frame abandoned, writes=%0d", we_count - w0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
